// File: rtl/aes_round_tail_if.sv
// rtl/aes_round_tail_if.sv - input/output valid/ready bundle for the AES round tail stage
// Byte k of each 128-bit word occupies bits [8k:8k+7]; row k%4, column k/4.
interface aes_round_tail_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic [0:127] in_round_key;
  logic         in_final;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;

  modport master (
    output in_valid, in_state, in_round_key, in_final, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_round_key, in_final, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_round_tail.sv
// rtl/aes_round_tail.sv - ShiftRows, MixColumns (skipped on final round) and AddRoundKey
// behind a valid/ready output register, one or two register stages deep.
module aes_round_tail #(
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_tail_if.slave  bus
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[8*(4*c+rw) +: 8] = s[8*(4*((c+rw)%4)+rw) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      // 03*x is written as xtime(x)^x
      r[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  logic [0:127] shifted;
  logic [0:127] mixed;

  // in_final is consumed here, so each word carries its own bypass decision forward
  assign shifted = shift_rows(bus.in_state);
  assign mixed   = bus.in_final ? shifted : mix_columns(shifted);

  if (PIPE_STAGES == 1) begin : g_one
    logic         out_valid_q;
    logic [0:127] out_state_q;
    logic         accept;

    assign accept = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_state_q <= '0;
      end else if (accept) begin
        out_valid_q <= bus.in_valid;
        if (bus.in_valid) out_state_q <= mixed ^ bus.in_round_key;
      end
    end

    assign bus.in_ready  = accept;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
  end else begin : g_two
    logic         a_valid;
    logic [0:127] a_state;
    logic [0:127] a_key;
    logic         out_valid_q;
    logic [0:127] out_state_q;
    logic         b_adv;
    logic         a_adv;

    assign b_adv = !out_valid_q || bus.out_ready;
    assign a_adv = !a_valid || b_adv;

    always_ff @(posedge clk) begin
      if (rst) begin
        a_valid     <= 1'b0;
        a_state     <= '0;
        a_key       <= '0;
        out_valid_q <= 1'b0;
        out_state_q <= '0;
      end else begin
        if (b_adv) begin
          out_valid_q <= a_valid;
          if (a_valid) out_state_q <= a_state ^ a_key;
        end
        if (a_adv) begin
          a_valid <= bus.in_valid;
          if (bus.in_valid) begin
            a_state <= mixed;
            a_key   <= bus.in_round_key;
          end
        end
      end
    end

    assign bus.in_ready  = a_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
  end

endmodule

// File: tb/tb_aes_round_tail.sv
// tb/tb_aes_round_tail.sv - scoreboard bench driving one- and two-stage instances
// of aes_round_tail with directed FIPS-197 vectors, stalls, reset and random words.
module tb_aes_round_tail;

  typedef struct {
    logic [0:127] d;
    int           acc;
    bit           exact;
  } exp_t;

  localparam logic [0:127] V1S  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [0:127] V1K  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [0:127] R2   = 128'h7445a32768e07e1f9be228c8344beee0;
  localparam logic [0:127] KEY6 = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  aes_round_tail_if bus1();
  aes_round_tail_if bus2();

  aes_round_tail #(.PIPE_STAGES(1)) u_p1 (.clk(clk), .rst(rst), .bus(bus1));
  aes_round_tail #(.PIPE_STAGES(2)) u_p2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [0:127] model(input logic [0:127] s, input logic [0:127] k, input logic f);
    logic [7:0]   st[4][4];
    logic [7:0]   sr[4][4];
    logic [7:0]   cf[4];
    logic [7:0]   acc;
    logic [0:127] res;
    cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        st[r][c] = s[8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[r][c] = st[r][(c+r)%4];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        acc = 8'h00;
        if (f) acc = sr[r][c];
        else for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j-r+4)%4], sr[j][c]);
        res[8*(4*c+r) +: 8] = acc ^ k[8*(4*c+r) +: 8];
      end
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) chk("spurious_p1", bus1.out_valid, 0);
      else begin
        e1 = q1.pop_front();
        chk("data_p1", bus1.out_state, e1.d);
        if (e1.exact) chk("lat_p1", cyc - e1.acc, 1);
      end
    end
    if (!rst && bus2.out_valid && bus2.out_ready) begin
      if (q2.size() == 0) chk("spurious_p2", bus2.out_valid, 0);
      else begin
        e2 = q2.pop_front();
        chk("data_p2", bus2.out_state, e2.d);
        if (e2.exact) chk("lat_p2", cyc - e2.acc, 2);
      end
    end
  end

  task automatic send1(input logic [0:127] s, input logic [0:127] k, input logic f,
                       input logic [0:127] exp, input bit exact);
    bit ok;
    ok = 0;
    bus1.in_state = s; bus1.in_round_key = k; bus1.in_final = f; bus1.in_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (bus1.in_ready) begin
        q1.push_back('{exp, cyc, exact});
        ok = 1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout_p1", bus1.in_ready, 1);
    bus1.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [0:127] s, input logic [0:127] k, input logic f,
                       input logic [0:127] exp, input bit exact);
    bit ok;
    ok = 0;
    bus2.in_state = s; bus2.in_round_key = k; bus2.in_final = f; bus2.in_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (bus2.in_ready) begin
        q2.push_back('{exp, cyc, exact});
        ok = 1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout_p2", bus2.in_ready, 1);
    bus2.in_valid = 1'b0;
  endtask

  logic [0:127] rs, rk;
  logic         rf;
  logic [0:127] held;

  initial begin
    bus1.in_valid = 0; bus1.in_state = '0; bus1.in_round_key = '0; bus1.in_final = 0; bus1.out_ready = 1;
    bus2.in_valid = 0; bus2.in_state = '0; bus2.in_round_key = '0; bus2.in_final = 0; bus2.out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid_p1", bus1.out_valid, 0);
    chk("rst_state_p1", bus1.out_state, 0);
    chk("rst_ready_p1", bus1.in_ready, 1);
    chk("rst_valid_p2", bus2.out_valid, 0);
    chk("rst_state_p2", bus2.out_state, 0);
    chk("rst_ready_p2", bus2.in_ready, 1);
    @(posedge clk); #1;

    // one-stage: FIPS round 1, final-round bypass, key-only, random words
    send1(V1S, V1K, 0, R1, 1);
    chk("t1_valid_next_cycle", bus1.out_valid, 1);
    chk("t1_state_next_cycle", bus1.out_state, R1);
    send1(V1S, V1K, 1, R2, 1);
    send1('0, KEY6, 0, KEY6, 1);
    for (int i = 0; i < 4; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      rf = 1'($urandom_range(0, 1));
      send1(rs, rk, rf, model(rs, rk, rf), 1);
    end
    repeat (2) @(posedge clk); #1;

    // one-stage backpressure: held result, second vector refused until drain
    bus1.out_ready = 0;
    send1(V1S, V1K, 0, R1, 0);
    bus1.in_state = V1S; bus1.in_round_key = V1K; bus1.in_final = 1; bus1.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid_p1", bus1.out_valid, 1);
      chk("stall_state_p1", bus1.out_state, R1);
      chk("stall_ready_p1", bus1.in_ready, 0);
      @(posedge clk); #1;
    end
    bus1.out_ready = 1;
    @(negedge clk);
    chk("drain_ready_p1", bus1.in_ready, 1);
    if (bus1.in_ready) q1.push_back('{R2, cyc, 1'b1});
    @(posedge clk); #1;
    bus1.in_valid = 0;
    repeat (2) @(posedge clk); #1;

    // two-stage streaming: vectors 1, 2, 1 back to back
    send2(V1S, V1K, 0, R1, 1);
    send2(V1S, V1K, 1, R2, 1);
    send2(V1S, V1K, 0, R1, 1);
    send2('0, KEY6, 0, KEY6, 1);
    for (int i = 0; i < 4; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      rf = 1'($urandom_range(0, 1));
      send2(rs, rk, rf, model(rs, rk, rf), 1);
    end
    repeat (3) @(posedge clk); #1;

    // two-stage backpressure: both registers full, third word refused
    bus2.out_ready = 0;
    send2(V1S, V1K, 1, R2, 0);
    send2('0, KEY6, 0, KEY6, 0);
    bus2.in_state = V1S; bus2.in_round_key = V1K; bus2.in_final = 0; bus2.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid_p2", bus2.out_valid, 1);
      chk("stall_state_p2", bus2.out_state, R2);
      chk("stall_ready_p2", bus2.in_ready, 0);
      @(posedge clk); #1;
    end
    bus2.out_ready = 1;
    @(negedge clk);
    chk("drain_ready_p2", bus2.in_ready, 1);
    if (bus2.in_ready) q2.push_back('{R1, cyc, 1'b0});
    @(posedge clk); #1;
    bus2.in_valid = 0;
    repeat (4) @(posedge clk); #1;

    // reset while results are held in both instances
    bus1.out_ready = 0;
    bus2.out_ready = 0;
    rs = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    held = model(rs, rk, 0);
    send1(rs, rk, 0, held, 0);
    send2(rs, rk, 0, held, 0);
    send2(V1S, V1K, 0, R1, 0);
    rst = 1;
    q1.delete();
    q2.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_valid_p1", bus1.out_valid, 0);
    chk("mid_rst_state_p1", bus1.out_state, 0);
    chk("mid_rst_ready_p1", bus1.in_ready, 1);
    chk("mid_rst_valid_p2", bus2.out_valid, 0);
    chk("mid_rst_state_p2", bus2.out_state, 0);
    chk("mid_rst_ready_p2", bus2.in_ready, 1);
    @(posedge clk); #1;
    bus1.out_ready = 1;
    bus2.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_p1", bus1.out_valid, 0);
      chk("no_stale_p2", bus2.out_valid, 0);
    end
    @(posedge clk); #1;

    send1(V1S, V1K, 0, R1, 1);
    send2(V1S, V1K, 1, R2, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_drained_p1", q1.size(), 0);
    chk("sb_drained_p2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
